// File: rtl/uart_rx_gen.sv
// uart_rx_gen: oversampling UART receiver with a two-flop input synchronizer,
// mid-bit sampling, configurable data/stop bits and frame-error reporting.
// Optional parity checking is compiled in with `define UART_RX_GEN_PARITY_EN;
// without it the PARITY state is absent and o_PARITY_ERR is constant 0.
module uart_rx_gen #(
  parameter int c_CYCLES_PER_BIT = 217,
  parameter int c_DATA_BITS      = 8,
  parameter int c_STOP_BITS      = 1,
  parameter int c_PARITY_ODD     = 0
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic                   i_SERIAL_DATA,
  output logic [c_DATA_BITS-1:0] o_DATA_RX,
  output logic                   o_RX_DATA_VALID,
  output logic                   o_FRAME_ERR,
  output logic                   o_PARITY_ERR,
  output logic                   o_BUSY
);

  localparam int CNT_W = $clog2(c_CYCLES_PER_BIT);
  localparam int IDX_W = $clog2(c_DATA_BITS);

  // Counter values at which the start bit is re-checked and the other bits are sampled.
  // Re-checking the start bit halfway in lets every later sample land near a bit centre.
  localparam logic [CNT_W-1:0] c_MID       = CNT_W'((c_CYCLES_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] c_LAST      = CNT_W'(c_CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(c_DATA_BITS - 1);
  localparam logic             c_LAST_STOP = 1'(c_STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_GEN_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t state_q, state_d;

  logic                   sync1_q, sync2_q;
  logic                   rx_sync;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [c_DATA_BITS-1:0] shift_q, shift_d;
  logic                   ferr_pend_q, ferr_pend_d;
  logic [c_DATA_BITS-1:0] data_q, data_d;
  logic                   ferr_q, ferr_d;
  logic                   valid_q, valid_d;
`ifdef UART_RX_GEN_PARITY_EN
  logic                   perr_pend_q, perr_pend_d;
  logic                   perr_q, perr_d;
  logic                   c_ODD_BIT;
  assign c_ODD_BIT = 1'(c_PARITY_ODD);
`else
  logic                   unused_parity_cfg;
  assign unused_parity_cfg = 1'(c_PARITY_ODD);
`endif

  // Two-stage synchronizer for the asynchronous line; it resets to the idle (high) level.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_SERIAL_DATA;
      sync2_q <= sync1_q;
    end
  end

  assign rx_sync = sync2_q;

  // State, counters, shift register and reported outputs.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      ferr_pend_q <= 1'b0;
      data_q      <= '0;
      ferr_q      <= 1'b0;
      valid_q     <= 1'b0;
`ifdef UART_RX_GEN_PARITY_EN
      perr_pend_q <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      ferr_pend_q <= ferr_pend_d;
      data_q      <= data_d;
      ferr_q      <= ferr_d;
      valid_q     <= valid_d;
`ifdef UART_RX_GEN_PARITY_EN
      perr_pend_q <= perr_pend_d;
      perr_q      <= perr_d;
`endif
    end
  end

  // Next-state and datapath logic; the counter is cleared on every state change.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    shift_d     = shift_q;
    ferr_pend_d = ferr_pend_q;
    data_d      = data_q;
    ferr_d      = ferr_q;
    valid_d     = 1'b0;
`ifdef UART_RX_GEN_PARITY_EN
    perr_pend_d = perr_pend_q;
    perr_d      = perr_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_sync) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == c_MID) begin
          cnt_d = '0;
          if (!rx_sync) begin
            state_d     = DATA;
            bit_idx_d   = '0;
            stop_idx_d  = 1'b0;
            ferr_pend_d = 1'b0;
`ifdef UART_RX_GEN_PARITY_EN
            perr_pend_d = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt_q == c_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_sync;
          if (bit_idx_q == c_LAST_IDX) begin
            bit_idx_d = '0;
`ifdef UART_RX_GEN_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end

`ifdef UART_RX_GEN_PARITY_EN
      PARITY: begin
        if (cnt_q == c_LAST) begin
          cnt_d       = '0;
          perr_pend_d = (^shift_q) ^ rx_sync ^ c_ODD_BIT;
          state_d     = STOP;
        end
      end
`endif

      STOP: begin
        if (cnt_q == c_LAST) begin
          cnt_d = '0;
          if (stop_idx_q == c_LAST_STOP) begin
            data_d     = shift_q;
            ferr_d     = ferr_pend_q | ~rx_sync;
`ifdef UART_RX_GEN_PARITY_EN
            perr_d     = perr_pend_q;
`endif
            valid_d    = 1'b1;
            stop_idx_d = 1'b0;
            state_d    = IDLE;
          end else begin
            ferr_pend_d = ferr_pend_q | ~rx_sync;
            stop_idx_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_DATA_RX       = data_q;
  assign o_FRAME_ERR     = ferr_q;
  assign o_RX_DATA_VALID = valid_q;
  assign o_BUSY          = (state_q != IDLE);
`ifdef UART_RX_GEN_PARITY_EN
  assign o_PARITY_ERR    = perr_q;
`else
  assign o_PARITY_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_gen.sv
// tb_uart_rx_gen: scoreboard bench for uart_rx_gen. Instance A runs 8 data bits /
// 1 stop bit, instance B runs 5 data bits / 2 stop bits, both at 16 cycles per bit.
// Honours UART_RX_GEN_PARITY_EN so it matches whichever build of the receiver it sees.
module tb_uart_rx_gen;

  localparam int C = 16;
`ifdef UART_RX_GEN_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       serA, serB;
  logic [7:0] dataA;
  logic [4:0] dataB;
  logic       validA, ferrA, perrA, busyA;
  logic       validB, ferrB, perrB, busyB;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    int         lat;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];
  exp_t eA, eB;

  int   cycA = 0, riseA = 0, cycB = 0, riseB = 0;
  logic prevBusyA = 1'b0, prevValidA = 1'b0, prevBusyB = 1'b0, prevValidB = 1'b0;

  uart_rx_gen #(.c_CYCLES_PER_BIT(C), .c_DATA_BITS(8), .c_STOP_BITS(1), .c_PARITY_ODD(0)) dutA (
    .i_CLK(clk), .i_RST(rst), .i_SERIAL_DATA(serA),
    .o_DATA_RX(dataA), .o_RX_DATA_VALID(validA), .o_FRAME_ERR(ferrA),
    .o_PARITY_ERR(perrA), .o_BUSY(busyA));

  uart_rx_gen #(.c_CYCLES_PER_BIT(C), .c_DATA_BITS(5), .c_STOP_BITS(2), .c_PARITY_ODD(0)) dutB (
    .i_CLK(clk), .i_RST(rst), .i_SERIAL_DATA(serB),
    .o_DATA_RX(dataB), .o_RX_DATA_VALID(validB), .o_FRAME_ERR(ferrB),
    .o_PARITY_ERR(perrB), .o_BUSY(busyB));

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveBit(input int which, input logic b);
    if (which == 0) serA = b;
    else            serB = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  // Queues the hand-computed result, then shifts one complete frame onto the chosen line.
  task automatic applyStimulus(input int which, input logic [7:0] data, input logic parBit,
                               input logic stopVal, input logic expFerr, input logic expPerr);
    int   nd;
    int   ns;
    exp_t e;
    nd     = (which == 0) ? 8 : 5;
    ns     = (which == 0) ? 1 : 2;
    e.data = data;
    e.ferr = expFerr;
    e.perr = expPerr;
    e.lat  = (C - 1) / 2 + (nd + P + ns) * C + 1;
    if (which == 0) qA.push_back(e);
    else            qB.push_back(e);
    driveBit(which, 1'b0);
    for (int i = 0; i < nd; i++) driveBit(which, data[i]);
    if (P == 1) driveBit(which, parBit);
    for (int s = 0; s < ns; s++) driveBit(which, stopVal);
    if (which == 0) serA = 1'b1;
    else            serB = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor A: pops the scoreboard on each valid pulse and measures busy-rise to valid latency.
  always @(negedge clk) begin
    cycA++;
    if (busyA && !prevBusyA) riseA = cycA;
    if (validA) begin
      checkOutput("A_valid_single_cycle", prevValidA, 1'b0);
      checkOutput("A_valid_expected", qA.size() > 0, 1'b1);
      if (qA.size() > 0) begin
        eA = qA.pop_front();
        checkOutput("A_data", dataA, eA.data);
        checkOutput("A_frame_err", ferrA, eA.ferr);
        checkOutput("A_parity_err", perrA, eA.perr);
        checkOutput("A_latency", cycA - riseA, eA.lat);
      end
    end
    prevBusyA  = busyA;
    prevValidA = validA;
  end

  // Monitor B: same scoreboard check for the 5-data-bit, 2-stop-bit instance.
  always @(negedge clk) begin
    cycB++;
    if (busyB && !prevBusyB) riseB = cycB;
    if (validB) begin
      checkOutput("B_valid_single_cycle", prevValidB, 1'b0);
      checkOutput("B_valid_expected", qB.size() > 0, 1'b1);
      if (qB.size() > 0) begin
        eB = qB.pop_front();
        checkOutput("B_data", dataB, eB.data[4:0]);
        checkOutput("B_frame_err", ferrB, eB.ferr);
        checkOutput("B_parity_err", perrB, eB.perr);
        checkOutput("B_latency", cycB - riseB, eB.lat);
      end
    end
    prevBusyB  = busyB;
    prevValidB = validB;
  end

  initial begin
    rst  = 1'b1;
    serA = 1'b1;
    serB = 1'b1;
    idle(3);
    $display("[TB] reset state");
    checkOutput("rst_data", dataA, 8'h00);
    checkOutput("rst_valid", validA, 1'b0);
    checkOutput("rst_ferr", ferrA, 1'b0);
    checkOutput("rst_perr", perrA, 1'b0);
    checkOutput("rst_busy", busyA, 1'b0);
    rst = 1'b0;
    idle(5);

    $display("[TB] clean 8N1 frame 0xA5");
    applyStimulus(0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(20);

    $display("[TB] 4-cycle low glitch on idle line");
    serA = 1'b0;
    idle(4);
    serA = 1'b1;
    idle(2);
    checkOutput("glitch_busy_high", busyA, 1'b1);
    idle(20);
    checkOutput("glitch_busy_low", busyA, 1'b0);
    checkOutput("glitch_data_hold", dataA, 8'hA5);

    $display("[TB] frame 0x3C with low stop bit, then clean 0x01");
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(30);
    checkOutput("ferr_hold", ferrA, 1'b1);
    checkOutput("ferr_busy_low", busyA, 1'b0);
    applyStimulus(0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(20);

`ifdef UART_RX_GEN_PARITY_EN
    $display("[TB] even parity on 0x07");
    applyStimulus(0, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(20);
    checkOutput("perr_hold", perrA, 1'b1);
    applyStimulus(0, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(20);
`endif

    $display("[TB] back-to-back 5-bit, 2-stop frames 0x15, 0x0A");
    applyStimulus(1, 8'h15, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 8'h0A, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(20);
    checkOutput("B_last_data_hold", dataB, 5'h0A);

    $display("[TB] reset during DATA of frame 0xFF");
    serA = 1'b0;
    idle(C);
    serA = 1'b1;
    idle(3 * C);
    checkOutput("midframe_busy", busyA, 1'b1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    checkOutput("midrst_data", dataA, 8'h00);
    checkOutput("midrst_valid", validA, 1'b0);
    checkOutput("midrst_ferr", ferrA, 1'b0);
    checkOutput("midrst_perr", perrA, 1'b0);
    checkOutput("midrst_busy", busyA, 1'b0);
    idle(8 * C);
    checkOutput("midrst_no_restart", busyA, 1'b0);
    applyStimulus(0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      if (qA.size() == 0 && qB.size() == 0) break;
      idle(1);
    end
    idle(5);
    checkOutput("A_all_frames_seen", qA.size(), 0);
    checkOutput("B_all_frames_seen", qB.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
